// File: rtl/conv_tree_pkg.sv
// Shared constants and FSM encoding for the serial-to-parallel word deserializer.
package conv_tree_pkg;

  localparam int DEFAULT_INPUTS_NUM = 256;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } deser_state_e;

endpackage

// File: rtl/deser_collector.sv
// Frame collector: hunts for frame_start, shifts bits LSB-first into a word, flags completion/abort.
// Latency: word/word_done are combinational for the accepting cycle; state advances on the edge.
// Backpressure: none, never stalls; serial_valid low simply freezes all state.
module deser_collector
  import conv_tree_pkg::*;
#(
  parameter int INPUTS_NUM = DEFAULT_INPUTS_NUM,
  parameter int CNT_W      = $clog2(INPUTS_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  input  logic                  frame_start,
  output logic [INPUTS_NUM-1:0] word,
  output logic                  word_done,
  output logic                  frame_abort
);

  deser_state_e          state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [INPUTS_NUM-1:0] sr_q, sr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      count_q <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sr_d        = sr_q;
    word_done   = 1'b0;
    frame_abort = 1'b0;
    if (serial_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_start) begin
            sr_d    = '0;
            sr_d[0] = serial_in;
            count_d = CNT_W'(1);
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (frame_start) begin
            // A new frame start restarts the word in place; the partial word is lost.
            frame_abort = 1'b1;
            sr_d        = '0;
            sr_d[0]     = serial_in;
            count_d     = CNT_W'(1);
          end else begin
            sr_d[count_q] = serial_in;
            if (count_q == CNT_W'(INPUTS_NUM - 1)) begin
              word_done = 1'b1;
              count_d   = '0;
              state_d   = HUNT;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // The completed word is taken from the next-state view so the holder can load on this edge.
  assign word = sr_d;

endmodule

// File: rtl/conv_tree_deserializer.sv
// Serial-to-parallel deserializer with a single output holding register and error flags.
// Latency: PAR_VALID rises one cycle after the last bit of a frame is accepted.
// Backpressure: PAR_READY only drains the holder; a word completing into a full holder is dropped (OVERFLOW).
module conv_tree_deserializer
  import conv_tree_pkg::*;
#(
  parameter int INPUTS_NUM = DEFAULT_INPUTS_NUM,
  parameter int CNT_W      = $clog2(INPUTS_NUM)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SERIAL_IN,
  input  logic                  SERIAL_VALID,
  input  logic                  FRAME_START,
  output logic [INPUTS_NUM-1:0] PAR_OUT,
  output logic                  PAR_VALID,
  input  logic                  PAR_READY,
  output logic                  OVERFLOW,
  output logic                  FRAME_ERR
);

  logic [INPUTS_NUM-1:0] col_word;
  logic                  col_done;
  logic                  col_abort;

  logic [INPUTS_NUM-1:0] par_out_q;
  logic                  par_valid_q;
  logic                  overflow_q;
  logic                  frame_err_q;
  logic                  hold_load;
  logic                  hold_drain;

  deser_collector #(
    .INPUTS_NUM (INPUTS_NUM),
    .CNT_W      (CNT_W)
  ) u_collector (
    .clk          (CLK),
    .reset        (RESET),
    .serial_in    (SERIAL_IN),
    .serial_valid (SERIAL_VALID),
    .frame_start  (FRAME_START),
    .word         (col_word),
    .word_done    (col_done),
    .frame_abort  (col_abort)
  );

  // Loading while the current word is being handed off gives back-to-back delivery.
  assign hold_drain = par_valid_q && PAR_READY;
  assign hold_load  = col_done && (!par_valid_q || PAR_READY);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= col_abort;
      if (hold_load) begin
        par_out_q   <= col_word;
        par_valid_q <= 1'b1;
      end else if (hold_drain) begin
        par_valid_q <= 1'b0;
      end
      if (col_done && !hold_load) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign PAR_OUT   = par_out_q;
  assign PAR_VALID = par_valid_q;
  assign OVERFLOW  = overflow_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_conv_tree_deserializer.sv
// Bench for conv_tree_deserializer at INPUTS_NUM=8: directed frames plus random traffic against a frame-level model.
module tb_conv_tree_deserializer;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         SERIAL_IN = 1'b0;
  logic         SERIAL_VALID = 1'b0;
  logic         FRAME_START = 1'b0;
  logic [N-1:0] PAR_OUT;
  logic         PAR_VALID;
  logic         PAR_READY = 1'b0;
  logic         OVERFLOW;
  logic         FRAME_ERR;

  conv_tree_deserializer #(.INPUTS_NUM(N)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SERIAL_IN    (SERIAL_IN),
    .SERIAL_VALID (SERIAL_VALID),
    .FRAME_START  (FRAME_START),
    .PAR_OUT      (PAR_OUT),
    .PAR_VALID    (PAR_VALID),
    .PAR_READY    (PAR_READY),
    .OVERFLOW     (OVERFLOW),
    .FRAME_ERR    (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ferr_cnt = 0;
  int valid_at[$];
  logic [N-1:0] delivered[$];

  // Frame-level reference: bits of the frame in progress (empty = hunting) and the holder contents.
  bit           frame_q[$];
  logic [N-1:0] m_hold;
  bit           m_valid, m_ovf, m_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input bit v, input bit b, input bit fs, input bit rdy, input bit rst);
    bit           done;
    logic [N-1:0] w;
    done = 1'b0;
    w    = '0;
    if (rst) begin
      frame_q.delete();
      m_hold = '0; m_valid = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
      return;
    end
    m_ferr = 1'b0;
    if (v) begin
      if (fs) begin
        if (frame_q.size() > 0) m_ferr = 1'b1;
        frame_q.delete();
        frame_q.push_back(b);
      end else if (frame_q.size() > 0) begin
        frame_q.push_back(b);
        if (frame_q.size() == N) begin
          for (int k = 0; k < N; k++) w[k] = frame_q[k];
          done = 1'b1;
          frame_q.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_hold  = w;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, let the DUT sample, compare at the next falling edge.
  task automatic cycle(input bit v, input bit b, input bit fs, input bit rdy, input bit rst);
    SERIAL_VALID = v;
    SERIAL_IN    = b;
    FRAME_START  = fs;
    PAR_READY    = rdy;
    RESET        = rst;
    if (!rst && PAR_VALID && PAR_READY) delivered.push_back(PAR_OUT);
    model_step(v, b, fs, rdy, rst);
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    check("par_valid", {31'b0, PAR_VALID}, {31'b0, m_valid});
    check("par_out",   {24'b0, PAR_OUT},   {24'b0, m_hold});
    check("overflow",  {31'b0, OVERFLOW},  {31'b0, m_ovf});
    check("frame_err", {31'b0, FRAME_ERR}, {31'b0, m_ferr});
    if (PAR_VALID) valid_at.push_back(cyc);
    if (FRAME_ERR) ferr_cnt++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_bits(input logic [N-1:0] w, input int first, input int last, input bit rdy);
    for (int k = first; k <= last; k++) cycle(1'b1, w[k], (k == 0), rdy, 1'b0);
  endtask

  task automatic clear_logs();
    valid_at.delete();
    delivered.delete();
    ferr_cnt = 0;
  endtask

  initial begin
    int s0;
    logic [N-1:0] ones;
    ones = '1;
    @(negedge CLK);

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_par_out", {24'b0, PAR_OUT}, 32'h0);
    check("rst_par_valid", {31'b0, PAR_VALID}, 32'h0);

    // Plain frame, bits 1,0,1,1,0,0,1,0
    clear_logs();
    s0 = cyc;
    send_bits(8'h4D, 0, N - 1, 1'b1);
    idle(3, 1'b1);
    check("f4d_valid_cycles", valid_at.size(), 1);
    if (valid_at.size() > 0) check("f4d_latency", valid_at[0] - s0, N);
    check("f4d_word", {24'b0, PAR_OUT}, 32'h4D);

    // Same frame with a 3-cycle serial gap after bit 3
    clear_logs();
    s0 = cyc;
    send_bits(8'h4D, 0, 3, 1'b1);
    idle(3, 1'b1);
    send_bits(8'h4D, 4, N - 1, 1'b1);
    idle(2, 1'b1);
    check("gap_valid_cycles", valid_at.size(), 1);
    if (valid_at.size() > 0) check("gap_latency", valid_at[0] - s0, N + 3);
    check("gap_word", {24'b0, PAR_OUT}, 32'h4D);

    // Abort: restart at bit 5, then an all-ones frame
    clear_logs();
    send_bits(8'h12, 0, 4, 1'b1);
    send_bits(ones, 0, N - 1, 1'b1);
    idle(2, 1'b1);
    check("abort_ferr_pulses", ferr_cnt, 1);
    check("abort_words", valid_at.size(), 1);
    check("abort_word", {24'b0, PAR_OUT}, 32'hFF);

    // Overflow with the consumer stalled
    clear_logs();
    send_bits(8'h4D, 0, N - 1, 1'b0);
    send_bits(8'hA5, 0, N - 1, 1'b0);
    idle(2, 1'b0);
    check("ovf_hold", {24'b0, PAR_OUT}, 32'h4D);
    check("ovf_flag", {31'b0, OVERFLOW}, 32'h1);
    idle(3, 1'b1);
    check("ovf_delivered", delivered.size(), 1);
    if (delivered.size() > 0) check("ovf_delivered_word", {24'b0, delivered[0]}, 32'h4D);
    check("ovf_sticky", {31'b0, OVERFLOW}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Back-to-back frames
    clear_logs();
    send_bits(8'h01, 0, N - 1, 1'b1);
    send_bits(8'h02, 0, N - 1, 1'b1);
    idle(2, 1'b1);
    check("b2b_words", delivered.size(), 2);
    if (valid_at.size() == 2) check("b2b_spacing", valid_at[1] - valid_at[0], N);
    else check("b2b_valid_cycles", valid_at.size(), 2);
    if (delivered.size() == 2) begin
      check("b2b_first", {24'b0, delivered[0]}, 32'h01);
      check("b2b_second", {24'b0, delivered[1]}, 32'h02);
    end

    // Reset mid-word, then a fresh frame
    clear_logs();
    send_bits(8'h77, 0, 4, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("midrst_par_out", {24'b0, PAR_OUT}, 32'h0);
    check("midrst_valid", {31'b0, PAR_VALID}, 32'h0);
    check("midrst_ovf", {31'b0, OVERFLOW}, 32'h0);
    send_bits(8'h3C, 0, N - 1, 1'b1);
    idle(2, 1'b1);
    check("midrst_ferr", ferr_cnt, 0);
    check("midrst_word", {24'b0, PAR_OUT}, 32'h3C);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            1'($urandom),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_tree_deserializer.md
CONV_TREE_DESERIALIZER -- requirements
Module: conv_tree_deserializer

Interface
REQ-001 SHALL have parameter INPUTS_NUM, default 256: number of bits per parallel word (power of two, >= 4).
REQ-002 SHALL have parameter CNT_W, default $clog2(INPUTS_NUM): bit-counter width (derived, not overridden).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SERIAL_IN  input  1  serial data bit.
REQ-006 SHALL have port SERIAL_VALID  input  1  SERIAL_IN qualifier; one bit accepted per cycle when high.
REQ-007 SHALL have port FRAME_START  input  1  marks the accepted bit as bit 0 of a word; ignored when SERIAL_VALID is low.
REQ-008 SHALL have port PAR_OUT  output  INPUTS_NUM  assembled word.
REQ-009 SHALL have port PAR_VALID  output  1  PAR_OUT holds an undelivered word.
REQ-010 SHALL have port PAR_READY  input  1  consumer accepts PAR_OUT when PAR_VALID && PAR_READY.
REQ-011 SHALL have port OVERFLOW  output  1  sticky; a completed word was dropped.
REQ-012 SHALL have port FRAME_ERR  output  1  one-cycle pulse; a partial word was aborted.

Function
REQ-013 SHALL implement states HUNT (no word in progress) and COLLECT (word in progress).
REQ-014 In HUNT, an accepted bit with FRAME_START SHALL be stored as bit 0, set count to 1 and enter COLLECT; accepted bits without FRAME_START SHALL be discarded.
REQ-015 In COLLECT, an accepted bit without FRAME_START SHALL be stored at index count, LSB-first (bit k of the frame maps to PAR_OUT[k]), and count SHALL increment.
REQ-016 When the bit at index INPUTS_NUM-1 is accepted, the word SHALL be complete, count SHALL clear and the FSM SHALL return to HUNT; every word requires its own FRAME_START.
REQ-017 FRAME_START on an accepted bit in COLLECT SHALL abort the partial word, pulse FRAME_ERR in the next cycle, and store that bit as bit 0 of a new word (count=1, stay in COLLECT).
REQ-018 SERIAL_VALID low SHALL freeze the FSM, count and shift register.
REQ-019 A completed word SHALL be loaded into the output holding register and PAR_VALID SHALL rise in the cycle after the last bit is accepted (latency 1).
REQ-020 The holding register SHALL load if PAR_VALID is low, or if PAR_VALID && PAR_READY in the completion cycle (back-to-back delivery, no bubble).
REQ-021 If the holding register is full and not being drained on completion, the new word SHALL be dropped, PAR_OUT unchanged, and OVERFLOW set until reset.
REQ-022 PAR_OUT SHALL stay stable while PAR_VALID && !PAR_READY; PAR_VALID SHALL fall after the handshake unless a new word loads in the same cycle.
REQ-023 The shift/collect path SHALL never stall; it runs independently of PAR_READY.

Reset
REQ-024 RESET high at a rising edge SHALL force HUNT, count=0, PAR_OUT=0, PAR_VALID=0, OVERFLOW=0, FRAME_ERR=0; RESET overrides all other inputs in that cycle.
REQ-025 Reset mid-word SHALL discard the partial word without FRAME_ERR; a held undelivered word SHALL be discarded.
REQ-026 No asynchronous reset or latch SHALL be used; all storage SHALL be edge-triggered flip-flops.

Structure
REQ-027 Shared package conv_tree_pkg SHALL hold the default INPUTS_NUM constant and the FSM state enum (HUNT, COLLECT).
REQ-028 One sub-module deser_collector (FSM, counter, shift register, completion strobe) SHALL be instantiated; the output holding register and flags SHALL sit in the top.

Verification (INPUTS_NUM=8)
REQ-029 Bits 1,0,1,1,0,0,1,0 with FRAME_START on the first, PAR_READY=1 -> PAR_VALID for one cycle, one cycle after the last bit, PAR_OUT=8'h4D.
REQ-030 Same frame with SERIAL_VALID low for 3 cycles after bit 3 -> PAR_OUT=8'h4D, PAR_VALID delayed by exactly 3 cycles.
REQ-031 FRAME_START at bit 5, then 8 bits all 1 -> FRAME_ERR pulses once, PAR_OUT=8'hFF, no word from the aborted frame.
REQ-032 PAR_READY=0, two complete frames 8'h4D then 8'hA5 -> PAR_OUT stays 8'h4D, OVERFLOW=1; raising PAR_READY delivers only 8'h4D.
REQ-033 Back-to-back frames 8'h01, 8'h02 with PAR_READY=1 -> two PAR_VALID cycles exactly 8 cycles apart, PAR_OUT 8'h01 then 8'h02.
REQ-034 RESET pulse after bit 4 of a frame, then a new frame 8'h3C -> no FRAME_ERR, all outputs 0 after reset, PAR_OUT=8'h3C.
